// File: rtl/ads131a0x_timer_pkg.sv
// Shared register map, bit positions and helpers for the ADS131A0X multi-channel timer.
package ads131a0x_timer_pkg;

  localparam logic [2:0] OFF_STATUS     = 3'd0;
  localparam logic [2:0] OFF_CONTROL    = 3'd1;
  localparam logic [2:0] OFF_PERIOD     = 3'd2;
  localparam logic [2:0] OFF_PRESCALE   = 3'd3;
  localparam logic [2:0] OFF_SNAP       = 3'd4;
  localparam logic [2:0] OFF_COUNT      = 3'd5;

  localparam logic [2:0] OFF_START_MASK = 3'd0;
  localparam logic [2:0] OFF_STOP_MASK  = 3'd1;
  localparam logic [2:0] OFF_IRQ_PEND   = 3'd2;

  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  localparam int unsigned STAT_TO         = 0;
  localparam int unsigned STAT_RUN        = 1;
  localparam int unsigned STAT_MISSED_LSB = 8;

  localparam int unsigned         MISSED_W   = 8;
  localparam logic [MISSED_W-1:0] MISSED_MAX = 8'hFF;

  // Saturating increment for the missed-timeout counter.
  function automatic logic [MISSED_W-1:0] missed_inc(input logic [MISSED_W-1:0] v);
    return (v == MISSED_MAX) ? v : v + MISSED_W'(1);
  endfunction

endpackage

// File: rtl/ads131a0x_timer_channel.sv
// One timer channel: prescaler, down-counter, TO/MISSED tracking and its register file.
module ads131a0x_timer_channel
  import ads131a0x_timer_pkg::*;
#(
  parameter int unsigned COUNT_W        = 32,
  parameter int unsigned PRESC_W        = 16,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h017D783F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_status,
  input  logic        wr_control,
  input  logic        wr_period,
  input  logic        wr_prescale,
  input  logic        wr_snap,
  input  logic [31:0] wdata,
  input  logic        start,
  input  logic        stop,
  input  logic [2:0]  rd_offset,
  output logic [31:0] rd_data_c,
  output logic        irq,
  output logic        irq_next_c,
  output logic        timeout_pulse
);

  localparam logic [COUNT_W-1:0] PERIOD_RST = COUNT_W'(DEFAULT_PERIOD);

  logic                run_q, run_d;
  logic                to_q, to_d;
  logic                ito_q, ito_d;
  logic                cont_q, cont_d;
  logic [MISSED_W-1:0] missed_q, missed_d;
  logic [COUNT_W-1:0]  period_q, period_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [COUNT_W-1:0]  snap_q, snap_d;
  logic [PRESC_W-1:0]  prescale_q, prescale_d;
  logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
  logic                event_c;

  // Next-state: start beats stop beats counting; a STATUS clear loses to a same-cycle event.
  always_comb begin
    run_d      = run_q;
    to_d       = to_q;
    ito_d      = ito_q;
    cont_d     = cont_q;
    missed_d   = missed_q;
    period_d   = period_q;
    count_d    = count_q;
    snap_d     = snap_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    event_c    = 1'b0;

    if (wr_control) begin
      ito_d  = wdata[CTRL_ITO];
      cont_d = wdata[CTRL_CONT];
    end
    if (wr_period)   period_d   = wdata[COUNT_W-1:0];
    if (wr_prescale) prescale_d = wdata[PRESC_W-1:0];
    if (wr_snap)     snap_d     = count_q;

    if (start) begin
      count_d = period_q;
      pcnt_d  = '0;
      run_d   = 1'b1;
    end else if (stop) begin
      run_d = 1'b0;
    end else if (run_q) begin
      if (pcnt_q == prescale_q) begin
        pcnt_d = '0;
        if (count_q != '0) begin
          count_d = count_q - COUNT_W'(1);
        end else begin
          event_c = 1'b1;
          count_d = period_q;
          if (!cont_q) run_d = 1'b0;
        end
      end else if (pcnt_q > prescale_q) begin
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + PRESC_W'(1);
      end
    end else if (wr_period) begin
      count_d = wdata[COUNT_W-1:0];
    end

    if (wr_status) begin
      to_d     = 1'b0;
      missed_d = '0;
    end
    if (event_c) begin
      to_d = 1'b1;
      if (to_q && !wr_status) missed_d = missed_inc(missed_q);
    end
  end

  assign irq_next_c = to_d && ito_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q         <= 1'b0;
      to_q          <= 1'b0;
      ito_q         <= 1'b0;
      cont_q        <= 1'b0;
      missed_q      <= '0;
      period_q      <= PERIOD_RST;
      count_q       <= PERIOD_RST;
      snap_q        <= '0;
      prescale_q    <= '0;
      pcnt_q        <= '0;
      irq           <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      run_q         <= run_d;
      to_q          <= to_d;
      ito_q         <= ito_d;
      cont_q        <= cont_d;
      missed_q      <= missed_d;
      period_q      <= period_d;
      count_q       <= count_d;
      snap_q        <= snap_d;
      prescale_q    <= prescale_d;
      pcnt_q        <= pcnt_d;
      irq           <= irq_next_c;
      timeout_pulse <= event_c;
    end
  end

  always_comb begin
    rd_data_c = '0;
    case (rd_offset)
      OFF_STATUS:   rd_data_c = {16'd0, missed_q, 6'd0, run_q, to_q};
      OFF_CONTROL:  rd_data_c = {30'd0, cont_q, ito_q};
      OFF_PERIOD:   rd_data_c = 32'(period_q);
      OFF_PRESCALE: rd_data_c = 32'(prescale_q);
      OFF_SNAP:     rd_data_c = 32'(snap_q);
      OFF_COUNT:    rd_data_c = 32'(count_q);
      default:      rd_data_c = '0;
    endcase
  end

endmodule

// File: rtl/ads131a0x_multi_timer.sv
// Multi-channel interval timer with Avalon-MM slave: address decode, global start/stop bank, read mux.
module ads131a0x_multi_timer
  import ads131a0x_timer_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned COUNT_W        = 32,
  parameter int unsigned PRESC_W        = 16,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h017D783F,
  parameter int unsigned ADDR_W         = $clog2(CHANNELS + 1) + 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq,
  output logic [CHANNELS-1:0] irq_vec,
  output logic [CHANNELS-1:0] timeout_pulse
);

  localparam int unsigned BANK_W = ADDR_W - 3;

  logic [BANK_W-1:0]   bank;
  logic [2:0]          offset;
  logic                wr_en;
  logic                glob_wr;
  logic [CHANNELS-1:0] mask_start;
  logic [CHANNELS-1:0] mask_stop;
  logic [CHANNELS-1:0] irq_next_vec;
  logic [31:0]         ch_rd [CHANNELS];
  logic [31:0]         rd_next;

  assign bank    = address[ADDR_W-1:3];
  assign offset  = address[2:0];
  assign wr_en   = chipselect && !write_n;
  assign glob_wr = wr_en && (bank == BANK_W'(CHANNELS));

  // Mask writes hit every selected channel on the same edge to keep triggers phase-aligned.
  assign mask_start = (glob_wr && offset == OFF_START_MASK) ? writedata[CHANNELS-1:0] : '0;
  assign mask_stop  = (glob_wr && offset == OFF_STOP_MASK)  ? writedata[CHANNELS-1:0] : '0;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en && (bank == BANK_W'(c));

    ads131a0x_timer_channel #(
      .COUNT_W       (COUNT_W),
      .PRESC_W       (PRESC_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .wr_status    (ch_wr && offset == OFF_STATUS),
      .wr_control   (ch_wr && offset == OFF_CONTROL),
      .wr_period    (ch_wr && offset == OFF_PERIOD),
      .wr_prescale  (ch_wr && offset == OFF_PRESCALE),
      .wr_snap      (ch_wr && offset == OFF_SNAP),
      .wdata        (writedata),
      .start        ((ch_wr && offset == OFF_CONTROL && writedata[CTRL_START]) || mask_start[c]),
      .stop         ((ch_wr && offset == OFF_CONTROL && writedata[CTRL_STOP]) || mask_stop[c]),
      .rd_offset    (offset),
      .rd_data_c    (ch_rd[c]),
      .irq          (irq_vec[c]),
      .irq_next_c   (irq_next_vec[c]),
      .timeout_pulse(timeout_pulse[c])
    );
  end

  always_comb begin
    rd_next = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (bank == BANK_W'(c)) rd_next = ch_rd[c];
    end
    if (bank == BANK_W'(CHANNELS) && offset == OFF_IRQ_PEND) rd_next = 32'(irq_vec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_next;
      irq      <= |irq_next_vec;
    end
  end

endmodule

// File: tb/tb_ads131a0x_multi_timer.sv
// Self-checking bench for ads131a0x_multi_timer against an arithmetic timing model.
module tb_ads131a0x_multi_timer;

  localparam int CH = 4;
  localparam int AW = 6;
  localparam logic [31:0] DEF = 32'h017D783F;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;
  logic [CH-1:0] irq_vec;
  logic [CH-1:0] timeout_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ads131a0x_multi_timer dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .irq          (irq),
    .irq_vec      (irq_vec),
    .timeout_pulse(timeout_pulse)
  );

  function automatic logic [AW-1:0] ra(input int b, input int o);
    return AW'(b * 8 + o);
  endfunction

  // Timeout at edge k for a channel started at edge g: every (P+1)(S+1) clocks, once if one-shot.
  function automatic bit ev(input int k, input int g, input int p, input int s, input bit cont);
    int n;
    int l;
    n = k - g;
    l = (p + 1) * (s + 1);
    if (n <= 0 || (n % l) != 0) return 1'b0;
    return cont || (n == l);
  endfunction

  // Counter value after edge k for a channel started at edge g.
  function automatic int cnt_at(input int k, input int g, input int p, input int s, input bit cont);
    int n;
    int l;
    int m;
    n = k - g;
    l = (p + 1) * (s + 1);
    if (n < 0) return p;
    m = (!cont && n >= l) ? 0 : (n % l);
    return p - m / (s + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at a negedge; the write lands on edge cyc+1.
  task automatic wr(input int b, input int o, input logic [31:0] d);
    address = ra(b, o);
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input int b, input int o, output logic [31:0] d);
    address = ra(b, o);
    chipselect = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    logic [31:0]   d;
    logic [CH-1:0] exp_p;
    logic [CH-1:0] exp_i;
    logic [CH-1:0] mask;
    int e0, g, s, n_run;
    int pr [CH];
    int sr [CH];
    bit cr [CH];
    bit ir [CH];

    repeat (3) @(negedge clk);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    chk("rst_irq_vec", 32'(irq_vec), 32'h0);
    chk("rst_pulse", 32'(timeout_pulse), 32'h0);
    reset = 1'b0;

    for (int b = 0; b < 8; b++) begin
      for (int o = 0; o < 8; o++) begin
        rd(b, o, d);
        chk($sformatf("rst_reg_b%0d_o%0d", b, o), d, (b < CH && (o == 2 || o == 5)) ? DEF : 32'h0);
      end
    end

    // Continuous channel 0, PERIOD=4: pulse every 5 clocks, MISSED saturates.
    wr(0, 2, 32'd4);
    rd(0, 5, d);
    chk("c0_count_load", d, 32'd4);
    wr(0, 1, 32'h7);
    e0 = cyc;
    for (int i = 0; i < 1300; i++) begin
      step();
      exp_p = '0;
      exp_p[0] = ev(cyc, e0, 4, 0, 1'b1);
      chk("c0_pulse", 32'(timeout_pulse), 32'(exp_p));
      chk("c0_irq", {31'd0, irq}, {31'd0, (cyc >= e0 + 5)});
    end
    rd(0, 0, d);
    chk("c0_status_sat", d, 32'h0000FF03);

    // STATUS clear coinciding with a timeout keeps TO, zeroes MISSED.
    for (int i = 0; i < 10 && ((cyc + 1 - e0) % 5 != 0); i++) step();
    wr(0, 0, 32'h0);
    chk("c0_clr_evt_pulse", 32'(timeout_pulse), 32'h1);
    rd(0, 0, d);
    chk("c0_clr_evt_status", d, 32'h3);
    chk("c0_clr_evt_irq", {31'd0, irq}, 32'h1);
    for (int i = 0; i < 10 && ((cyc + 1 - e0) % 5 != 1); i++) step();
    wr(0, 0, 32'h0);
    chk("c0_clr_irq", {31'd0, irq}, 32'h0);
    chk("c0_clr_irq_vec", 32'(irq_vec), 32'h0);
    rd(0, 0, d);
    chk("c0_clr_status", d, 32'h2);

    // STOP mid-count: counter holds, no pulses.
    s = cyc + 1;
    wr(0, 1, 32'h8);
    rd(0, 5, d);
    chk("c0_stop_count", d, 32'(cnt_at(s - 1, e0, 4, 0, 1'b1)));
    rd(0, 0, d);
    chk("c0_stop_status", d, 32'h0);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("c0_stop_nopulse", 32'(timeout_pulse), 32'h0);
    end
    rd(0, 5, d);
    chk("c0_stop_count_hold", d, 32'(cnt_at(s - 1, e0, 4, 0, 1'b1)));

    // One-shot channel 1: PERIOD=2, PRESCALE=3 -> single pulse 12 clocks after start.
    wr(1, 2, 32'd2);
    wr(1, 3, 32'd3);
    wr(1, 1, 32'h5);
    g = cyc;
    for (int i = 0; i < 40; i++) begin
      step();
      exp_p = '0;
      exp_p[1] = ev(cyc, g, 2, 3, 1'b0);
      chk("c1_pulse", 32'(timeout_pulse), 32'(exp_p));
      chk("c1_irq", {31'd0, irq}, {31'd0, (cyc >= g + 12)});
    end
    chk("c1_irq_vec", 32'(irq_vec), 32'h2);
    rd(1, 0, d);
    chk("c1_status", d, 32'h1);
    rd(1, 5, d);
    chk("c1_count", d, 32'd2);
    rd(4, 2, d);
    chk("c1_irq_pend", d, 32'h2);
    wr(1, 0, 32'h0);

    // PERIOD change while running applies at the next reload; SNAP captures the live count.
    wr(2, 2, 32'd4);
    wr(2, 1, 32'h6);
    g = cyc;
    step();
    wr(2, 2, 32'd9);
    wr(2, 4, 32'h0);
    while (cyc < g + 30) begin
      step();
      exp_p = '0;
      exp_p[2] = ((cyc - g) == 5) || ((cyc - g) > 5 && ((cyc - g - 5) % 10) == 0);
      chk("c2_pulse", 32'(timeout_pulse), 32'(exp_p));
    end
    rd(2, 4, d);
    chk("c2_snap", d, 32'd2);
    rd(2, 2, d);
    chk("c2_period", d, 32'd9);
    wr(2, 1, 32'h8);

    // Global START_MASK with PERIOD 3,3,7,1.
    pr[0] = 3; pr[1] = 3; pr[2] = 7; pr[3] = 1;
    for (int c = 0; c < CH; c++) begin
      wr(c, 1, 32'h2);
      wr(c, 2, 32'(pr[c]));
      wr(c, 3, 32'h0);
      wr(c, 0, 32'h0);
    end
    wr(4, 0, 32'hF);
    g = cyc;
    for (int i = 0; i < 40; i++) begin
      step();
      for (int c = 0; c < CH; c++) exp_p[c] = ev(cyc, g, pr[c], 0, 1'b1);
      chk("mask_pulse", 32'(timeout_pulse), 32'(exp_p));
    end
    wr(4, 1, 32'hF);
    chk("mask_stop_nopulse", 32'(timeout_pulse), 32'h0);

    // Randomized rounds against the arithmetic model.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < CH; c++) begin
        pr[c] = int'($urandom_range(0, 6));
        sr[c] = int'($urandom_range(0, 3));
        cr[c] = 1'($urandom_range(0, 1));
        ir[c] = 1'($urandom_range(0, 1));
        wr(c, 1, {30'd0, cr[c], ir[c]});
        wr(c, 2, 32'(pr[c]));
        wr(c, 3, 32'(sr[c]));
        wr(c, 0, 32'h0);
      end
      mask = CH'($urandom_range(1, 15));
      n_run = int'($urandom_range(20, 60));
      wr(4, 0, 32'(mask));
      g = cyc;
      while (cyc < g + n_run - 1) begin
        step();
        for (int c = 0; c < CH; c++) begin
          exp_p[c] = mask[c] && ev(cyc, g, pr[c], sr[c], cr[c]);
          exp_i[c] = mask[c] && ir[c] && ((cyc - g) >= (pr[c] + 1) * (sr[c] + 1));
        end
        chk($sformatf("rnd%0d_pulse", r), 32'(timeout_pulse), 32'(exp_p));
        chk($sformatf("rnd%0d_irq_vec", r), 32'(irq_vec), 32'(exp_i));
        chk($sformatf("rnd%0d_irq", r), {31'd0, irq}, {31'd0, |exp_i});
      end
      wr(4, 1, 32'hF);
      chk($sformatf("rnd%0d_stop_nopulse", r), 32'(timeout_pulse), 32'h0);
      for (int c = 0; c < CH; c++) begin
        rd(c, 5, d);
        chk($sformatf("rnd%0d_count_c%0d", r, c), d,
            mask[c] ? 32'(cnt_at(g + n_run - 1, g, pr[c], sr[c], cr[c])) : 32'(pr[c]));
      end
    end

    // Reset in mid-count.
    wr(0, 3, 32'h0);
    wr(0, 2, 32'd3);
    wr(0, 1, 32'h7);
    repeat (7) step();
    reset = 1'b1;
    step();
    chk("mid_rst_pulse", 32'(timeout_pulse), 32'h0);
    chk("mid_rst_irq", {31'd0, irq}, 32'h0);
    chk("mid_rst_readdata", readdata, 32'h0);
    reset = 1'b0;
    rd(0, 5, d);
    chk("mid_rst_count", d, DEF);
    rd(0, 2, d);
    chk("mid_rst_period", d, DEF);
    rd(0, 0, d);
    chk("mid_rst_status", d, 32'h0);
    rd(0, 1, d);
    chk("mid_rst_control", d, 32'h0);
    rd(0, 4, d);
    chk("mid_rst_snap", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ads131a0x_multi_timer.md
# ads131a0x_multi_timer

Parametrised multi-channel interval timer with an Avalon-MM slave for the ADS131A0X Qsys system. It replaces the single fixed 32-bit interval timer. It adds:
- `CHANNELS` independent down-counters of width `COUNT_W`, each with its own prescaler.
- Per-channel one-shot/continuous mode and a saturating missed-timeout counter.
- A global register that starts or stops several channels in the same clock cycle, so ADC conversion triggers stay phase-aligned.

## Interface
- `CHANNELS`, 4: number of timer channels, 1–8.
- `COUNT_W`, 32: counter/period width, 8–32.
- `PRESC_W`, 16: prescaler width, 1–16.
- `DEFAULT_PERIOD`, 32'h017D783F: reset value of every PERIOD register and counter.
- `ADDR_W`, derived: $clog2(CHANNELS+1)+3.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  reset, synchronous, active-high.
- `address`  in  ADDR_W  word address; [ADDR_W-1:3] selects the bank, [2:0] the register offset.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `irq`  out  1  OR of `irq_vec`.
- `irq_vec`  out  CHANNELS  per-channel interrupt: TO && ITO.
- `timeout_pulse`  out  CHANNELS  registered one-cycle pulse on each timeout event.

## Operation
- Bank c (c < CHANNELS) holds channel c. Bank CHANNELS is the global bank. Any other bank reads 0 and ignores writes.
- Channel registers:
  - Offset 0, STATUS. Bit0 TO, bit1 RUN, bits[15:8] MISSED. Any write clears TO and MISSED.
  - Offset 1, CONTROL. Bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. Bits[1:0] are stored. START and STOP are write-only strobes.
  - Offset 2, PERIOD, COUNT_W bits.
  - Offset 3, PRESCALE, PRESC_W bits.
  - Offset 4, SNAP. A write copies the live counter; a read returns the copy.
  - Offset 5, COUNT. Read-only live counter.
  - Offsets 6–7 are reserved and read 0.
- Global bank:
  - Offset 0, START_MASK. Write-only; bit c starts channel c.
  - Offset 1, STOP_MASK. Write-only.
  - Offset 2, IRQ_PEND. Read-only `irq_vec`.
- Unused upper bits read 0.
- Starting a channel (START strobe or START_MASK bit):
  - Loads the counter from PERIOD and clears the prescaler.
  - Sets RUN the next cycle. This applies even if the channel is already running (restart).
- Prescaler:
  - Counts 0..PRESCALE while RUN=1.
  - A tick occurs when it equals PRESCALE, then it wraps to 0.
  - PRESCALE=0 gives a tick every clock.
- On a tick:
  - Counter ≠ 0: the counter decrements.
  - Counter = 0: timeout event. TO←1, `timeout_pulse`←1, counter←PERIOD. If CONT=0, RUN←0.
- Event spacing is (PERIOD+1)·(PRESCALE+1) clocks.
- PERIOD=0 with PRESCALE=0 gives a timeout every clock.
- A timeout event while TO is already 1 increments MISSED, saturating at 255.
- PERIOD write:
  - While stopped, the counter also loads the new value.
  - While running, the new value takes effect at the next reload only, with no forced restart.
- A PRESCALE write while running takes effect immediately. If the prescaler count is above the new PRESCALE, it wraps to 0 on the next clock without a tick.
- A STOP clears RUN. The counter and prescaler hold their values.
- Simultaneous events:
  - START and STOP in the same write, or the same mask bit in both global registers on different cycles: each write acts in its own cycle. Within one CONTROL write, START wins.
  - STATUS clear in the same cycle as a timeout event: TO=1, MISSED=0.
  - A SNAP write in the same cycle as a tick captures the pre-tick counter value.

## Timing
- Reset values:
  - `readdata`=0, `irq`=0, `irq_vec`=0, `timeout_pulse`=0.
  - Counters and PERIOD = DEFAULT_PERIOD (truncated to COUNT_W).
  - PRESCALE=0, CONTROL=0, RUN=0, TO=0, MISSED=0, SNAP=0.
- Reset in mid-count returns every register to these values on the next edge.
- Read latency is 1. `readdata` is registered from `address` every cycle, regardless of `chipselect`.
- Writes take effect on the clock edge where `chipselect` && !`write_n`. The stored value is visible to a read issued on the next cycle.
- The event is detected on edge k. On edge k:
  - TO updates.
  - `timeout_pulse` asserts, high for the cycle after edge k.
  - `irq` and `irq_vec` assert.
- Channels started in the same START_MASK write produce their first timeouts on the same edge when their PERIOD and PRESCALE values are equal.

## Structure
- Package `ads131a0x_timer_pkg` holds:
  - Register offset constants (STATUS, CONTROL, PERIOD, PRESCALE, SNAP, COUNT, START_MASK, STOP_MASK, IRQ_PEND).
  - CONTROL and STATUS bit positions.
  - MISSED width (8) and its saturation value.
- Sub-module `ads131a0x_timer_channel`, instantiated CHANNELS times via generate.
  - It holds the channel registers, prescaler, counter and the TO/MISSED logic.
  - Its inputs are decoded write strobes, a start and a stop.
  - Its outputs are the register read values, `irq` and the timeout pulse.
- The top level contains the address decode, global bank, read mux and `irq` OR.

## Test plan
- After reset, read every register and compare it to the reset values, including PERIOD read as 0x017D783F.
- Channel 0 at PERIOD=4, PRESCALE=0, CONT=1, ITO=1:
  - Write CONTROL=0x7 → first `timeout_pulse[0]` 5 clocks after RUN rises.
  - Subsequent pulses follow every 5 clocks.
  - `irq` stays high until a STATUS write, and MISSED counts to 255 and holds.
- One-shot mode at PERIOD=2, PRESCALE=3, CONTROL=0x5 → exactly one pulse, 12 clocks after start. After that, RUN=0 and COUNT=2.
- START_MASK write of 0xF with differing PERIOD values (3, 3, 7, 1) → channels 0 and 1 pulse on identical edges, and channel 3 pulses every 2 clocks.
- PERIOD write of 9 during a running count from 4 → the current interval still ends after 5 ticks, and the next interval lasts 10 ticks. SNAP taken mid-count matches the COUNT value read in the same cycle.
- STATUS write on the same edge as a timeout → TO=1, MISSED=0. STOP during a count → COUNT holds and no pulse occurs for 100 clocks.
